// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants for the scoreboarded register file
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 64;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int REG0_ADDR      = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits and registered busy population
module regfile_scoreboard #(
  parameter int ADDR_W = regfile_pkg::DEFAULT_ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [ADDR_W-1:0]    set_addr,
  input  logic                 clr_a_en,
  input  logic [ADDR_W-1:0]    clr_a_addr,
  input  logic                 clr_b_en,
  input  logic [ADDR_W-1:0]    clr_b_addr,
  output logic [2**ADDR_W-1:0] busy,
  output logic [ADDR_W:0]      busy_count
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_next;
  logic [ADDR_W:0]  count_next;

  // Set is applied after the clears so a same-cycle issue keeps the bit busy.
  always_comb begin
    busy_next = busy;
    if (clr_a_en) busy_next[clr_a_addr] = 1'b0;
    if (clr_b_en) busy_next[clr_b_addr] = 1'b0;
    if (set_en)   busy_next[set_addr]   = 1'b1;
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + {{ADDR_W{1'b0}}, busy_next[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

endmodule

// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - two-write, two-read register file with issue scoreboard
module scoreboard_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Rdy1,
  output logic              Rdy2,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RD2,
  input  logic [DATA_W-1:0] WriteData2,
  input  logic              RegWrite2,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueRD,
  output logic [ADDR_W:0]   BusyCount,
  output logic              WrConflict
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG0_ADDR);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic zero_rd, zero_rd2, zero_iss, zero_rs1, zero_rs2;
  logic wr_a, wr_b, conflict, issue_en;
  logic hit_a1, hit_b1, hit_a2, hit_b2;

  assign zero_rd  = (ZERO_REG != 0) && (RD == ZERO_ADDR);
  assign zero_rd2 = (ZERO_REG != 0) && (RD2 == ZERO_ADDR);
  assign zero_iss = (ZERO_REG != 0) && (IssueRD == ZERO_ADDR);
  assign zero_rs1 = (ZERO_REG != 0) && (RS1 == ZERO_ADDR);
  assign zero_rs2 = (ZERO_REG != 0) && (RS2 == ZERO_ADDR);

  // Effective commits: reset suppresses both, and port B loses a same-address collision.
  assign wr_a     = RegWrite && reset && !zero_rd;
  assign conflict = wr_a && RegWrite2 && (RD2 == RD);
  assign wr_b     = RegWrite2 && reset && !zero_rd2 && !conflict;
  assign issue_en = IssueValid && !zero_iss;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      WrConflict <= 1'b0;
    end else begin
      if (wr_a) regs[RD]  <= WriteData;
      if (wr_b) regs[RD2] <= WriteData2;
      WrConflict <= conflict;
    end
  end

  assign hit_a1 = wr_a && (RD == RS1);
  assign hit_b1 = wr_b && (RD2 == RS1);
  assign hit_a2 = wr_a && (RD == RS2);
  assign hit_b2 = wr_b && (RD2 == RS2);

  always_comb begin
    ReadData1 = regs[RS1];
    if (zero_rs1)                        ReadData1 = '0;
    else if ((BYPASS != 0) && hit_a1)    ReadData1 = WriteData;
    else if ((BYPASS != 0) && hit_b1)    ReadData1 = WriteData2;
  end

  always_comb begin
    ReadData2 = regs[RS2];
    if (zero_rs2)                        ReadData2 = '0;
    else if ((BYPASS != 0) && hit_a2)    ReadData2 = WriteData;
    else if ((BYPASS != 0) && hit_b2)    ReadData2 = WriteData2;
  end

  // A register being written this cycle reads as ready unless it is re-issued at the same time.
  assign Rdy1 = !busy[RS1] ||
                ((BYPASS != 0) && (hit_a1 || hit_b1) && !(issue_en && (IssueRD == RS1)));
  assign Rdy2 = !busy[RS2] ||
                ((BYPASS != 0) && (hit_a2 || hit_b2) && !(issue_en && (IssueRD == RS2)));

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en     (issue_en),
    .set_addr   (IssueRD),
    .clr_a_en   (wr_a),
    .clr_a_addr (RD),
    .clr_b_en   (wr_b),
    .clr_b_addr (RD2),
    .busy       (busy),
    .busy_count (BusyCount)
  );

endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb/tb_scoreboard_regfile.sv - directed bench for scoreboard_regfile (bypass and non-bypass)
module tb_scoreboard_regfile;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] RS1, RS2, RD, RD2, IssueRD;
  logic [DW-1:0] WriteData, WriteData2;
  logic          RegWrite, RegWrite2, IssueValid;

  logic [DW-1:0] b_rd1, b_rd2, n_rd1, n_rd2;
  logic          b_rdy1, b_rdy2, n_rdy1, n_rdy2;
  logic [AW:0]   b_cnt, n_cnt;
  logic          b_conf, n_conf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scoreboard_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .RS1(RS1), .RS2(RS2),
    .ReadData1(b_rd1), .ReadData2(b_rd2), .Rdy1(b_rdy1), .Rdy2(b_rdy2),
    .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite),
    .RD2(RD2), .WriteData2(WriteData2), .RegWrite2(RegWrite2),
    .IssueValid(IssueValid), .IssueRD(IssueRD),
    .BusyCount(b_cnt), .WrConflict(b_conf)
  );

  scoreboard_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .RS1(RS1), .RS2(RS2),
    .ReadData1(n_rd1), .ReadData2(n_rd2), .Rdy1(n_rdy1), .Rdy2(n_rdy2),
    .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite),
    .RD2(RD2), .WriteData2(WriteData2), .RegWrite2(RegWrite2),
    .IssueValid(IssueValid), .IssueRD(IssueRD),
    .BusyCount(n_cnt), .WrConflict(n_conf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 1'b0; RegWrite2 = 1'b0; IssueValid = 1'b0;
    RD = '0; RD2 = '0; IssueRD = '0; WriteData = '0; WriteData2 = '0;
  endtask

  task automatic test_reset();
    idle();
    RS1 = 5'd3; RS2 = 5'd7;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++; if (b_rd1 !== 64'd0) begin failures++; $display("FAIL reset_rd1 got=%0d exp=0", b_rd1); end
    checks++; if (b_cnt !== 6'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", b_cnt); end
    checks++; if (b_conf !== 1'b0) begin failures++; $display("FAIL reset_conf got=%0b exp=0", b_conf); end
    checks++; if (b_rdy1 !== 1'b1) begin failures++; $display("FAIL reset_rdy1 got=%0b exp=1", b_rdy1); end
  endtask

  task automatic test_write_read();
    RD = 5'd3; WriteData = 64'd100; RegWrite = 1'b1;
    tick();
    idle();
    RS1 = 5'd3;
    #1;
    checks++; if (b_rd1 !== 64'd100) begin failures++; $display("FAIL wr_rd_byp got=%0d exp=100", b_rd1); end
    checks++; if (n_rd1 !== 64'd100) begin failures++; $display("FAIL wr_rd_nb got=%0d exp=100", n_rd1); end
  endtask

  task automatic test_bypass();
    RS2 = 5'd3; RD = 5'd3; WriteData = 64'd200; RegWrite = 1'b1;
    #1;
    checks++; if (b_rd2 !== 64'd200) begin failures++; $display("FAIL bypass_rd2 got=%0d exp=200", b_rd2); end
    checks++; if (n_rd2 !== 64'd100) begin failures++; $display("FAIL nobypass_rd2 got=%0d exp=100", n_rd2); end
    tick();
    idle();
    #1;
    checks++; if (n_rd2 !== 64'd200) begin failures++; $display("FAIL nobypass_late got=%0d exp=200", n_rd2); end
    RS1 = 5'd7; RD2 = 5'd7; WriteData2 = 64'd11; RegWrite2 = 1'b1;
    #1;
    checks++; if (b_rd1 !== 64'd11) begin failures++; $display("FAIL bypass_portb got=%0d exp=11", b_rd1); end
    tick();
    idle();
  endtask

  task automatic test_conflict();
    RS1 = 5'd5; RD = 5'd5; RD2 = 5'd5; WriteData = 64'd7; WriteData2 = 64'd9;
    RegWrite = 1'b1; RegWrite2 = 1'b1;
    #1;
    checks++; if (b_rd1 !== 64'd7) begin failures++; $display("FAIL bypass_prec got=%0d exp=7", b_rd1); end
    checks++; if (b_conf !== 1'b0) begin failures++; $display("FAIL conf_early got=%0b exp=0", b_conf); end
    tick();
    idle();
    #1;
    checks++; if (b_conf !== 1'b1) begin failures++; $display("FAIL conf_pulse got=%0b exp=1", b_conf); end
    checks++; if (n_rd1 !== 64'd7) begin failures++; $display("FAIL conf_data got=%0d exp=7", n_rd1); end
    tick();
    checks++; if (b_conf !== 1'b0) begin failures++; $display("FAIL conf_one_cycle got=%0b exp=0", b_conf); end
    RD = 5'd0; RD2 = 5'd0; RegWrite = 1'b1; RegWrite2 = 1'b1;
    tick();
    idle();
    checks++; if (b_conf !== 1'b0) begin failures++; $display("FAIL conf_reg0 got=%0b exp=0", b_conf); end
  endtask

  task automatic test_scoreboard();
    IssueValid = 1'b1; IssueRD = 5'd4;
    tick();
    IssueRD = 5'd6;
    tick();
    idle();
    RS1 = 5'd4;
    #1;
    checks++; if (b_cnt !== 6'd2) begin failures++; $display("FAIL sb_cnt2 got=%0d exp=2", b_cnt); end
    checks++; if (b_rdy1 !== 1'b0) begin failures++; $display("FAIL sb_rdy_busy got=%0b exp=0", b_rdy1); end
    RD = 5'd4; WriteData = 64'd1; RegWrite = 1'b1;
    #1;
    checks++; if (b_rdy1 !== 1'b1) begin failures++; $display("FAIL sb_rdy_fwd got=%0b exp=1", b_rdy1); end
    checks++; if (n_rdy1 !== 1'b0) begin failures++; $display("FAIL sb_rdy_nofwd got=%0b exp=0", n_rdy1); end
    tick();
    idle();
    #1;
    checks++; if (b_cnt !== 6'd1) begin failures++; $display("FAIL sb_cnt1 got=%0d exp=1", b_cnt); end
    checks++; if (n_rdy1 !== 1'b1) begin failures++; $display("FAIL sb_rdy_clr got=%0b exp=1", n_rdy1); end
    IssueValid = 1'b1; IssueRD = 5'd6;
    tick();
    checks++; if (b_cnt !== 6'd1) begin failures++; $display("FAIL sb_reissue got=%0d exp=1", b_cnt); end
    IssueRD = 5'd9; RD = 5'd9; WriteData = 64'd3; RegWrite = 1'b1;
    tick();
    idle();
    RS1 = 5'd9;
    #1;
    checks++; if (b_cnt !== 6'd2) begin failures++; $display("FAIL sb_issue_wins got=%0d exp=2", b_cnt); end
    checks++; if (b_rdy1 !== 1'b0) begin failures++; $display("FAIL sb_rdy9 got=%0b exp=0", b_rdy1); end
    IssueValid = 1'b1; IssueRD = 5'd10; RD = 5'd6; RegWrite = 1'b1;
    tick();
    idle();
    checks++; if (b_cnt !== 6'd2) begin failures++; $display("FAIL sb_net got=%0d exp=2", b_cnt); end
  endtask

  task automatic test_zero_reg();
    RS1 = 5'd0; RD = 5'd0; WriteData = 64'd55; RegWrite = 1'b1;
    IssueValid = 1'b1; IssueRD = 5'd0;
    #1;
    checks++; if (b_rd1 !== 64'd0) begin failures++; $display("FAIL zero_fwd got=%0d exp=0", b_rd1); end
    tick();
    idle();
    #1;
    checks++; if (b_rd1 !== 64'd0) begin failures++; $display("FAIL zero_read got=%0d exp=0", b_rd1); end
    checks++; if (b_cnt !== 6'd2) begin failures++; $display("FAIL zero_cnt got=%0d exp=2", b_cnt); end
  endtask

  task automatic test_reset_mid();
    IssueValid = 1'b1; IssueRD = 5'd11;
    tick();
    idle();
    checks++; if (b_cnt !== 6'd3) begin failures++; $display("FAIL mid_cnt3 got=%0d exp=3", b_cnt); end
    RS1 = 5'd5; RS2 = 5'd3;
    reset = 1'b0;
    IssueValid = 1'b1; IssueRD = 5'd12;
    RD = 5'd5; WriteData = 64'd77; RegWrite = 1'b1;
    RD2 = 5'd5; WriteData2 = 64'd88; RegWrite2 = 1'b1;
    #1;
    checks++; if (b_rd1 !== 64'd7) begin failures++; $display("FAIL mid_comb_read got=%0d exp=7", b_rd1); end
    tick();
    reset = 1'b1;
    idle();
    #1;
    checks++; if (b_rd1 !== 64'd0) begin failures++; $display("FAIL mid_rd1 got=%0d exp=0", b_rd1); end
    checks++; if (b_rd2 !== 64'd0) begin failures++; $display("FAIL mid_rd2 got=%0d exp=0", b_rd2); end
    checks++; if (b_cnt !== 6'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", b_cnt); end
    checks++; if (b_conf !== 1'b0) begin failures++; $display("FAIL mid_conf got=%0b exp=0", b_conf); end
    checks++; if (n_cnt !== 6'd0) begin failures++; $display("FAIL mid_cnt_nb got=%0d exp=0", n_cnt); end
  endtask

  initial begin
    reset = 1'b1;
    RS1 = '0; RS2 = '0;
    idle();
    #2;
    test_reset();
    test_write_read();
    test_bypass();
    test_conflict();
    test_scoreboard();
    test_zero_reg();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width; depth is 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding is enabled when 1.
REQ-005 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-006 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-007 SHALL have ports RS1, RS2  input  ADDR_W  read addresses.
REQ-008 SHALL have ports ReadData1, ReadData2  output  DATA_W  read data.
REQ-009 SHALL have ports Rdy1, Rdy2  output  1  addressed register holds committed data (not busy).
REQ-010 SHALL have ports RD, WriteData, RegWrite  input  ADDR_W/DATA_W/1  write port A.
REQ-011 SHALL have ports RD2, WriteData2, RegWrite2  input  ADDR_W/DATA_W/1  write port B.
REQ-012 SHALL have ports IssueValid, IssueRD  input  1/ADDR_W  mark destination register busy.
REQ-013 SHALL have port BusyCount  output  ADDR_W+1  number of busy registers.
REQ-014 SHALL have port WrConflict  output  1  registered pulse: both write ports hit the same address.

Function
REQ-015 SHALL perform reads combinationally from current array contents.
REQ-016 SHALL commit writes on the rising edge of clk when the corresponding write enable is 1.
REQ-017 SHALL, when both write ports target the same address in one cycle, commit port A data, drop port B, and assert WrConflict for exactly the following cycle.
REQ-018 SHALL, with ZERO_REG=1, return 0 for reads of address 0, ignore writes to it, never mark it busy, and raise no WrConflict for it.
REQ-019 SHALL, with BYPASS=1, return the write data on ReadDataN when RSN equals an enabled write address in the same cycle; port A takes precedence over port B.
REQ-020 SHALL, with BYPASS=0, return pre-write contents in the write cycle (one-cycle read-after-write latency).
REQ-021 SHALL set busy[IssueRD] at the clock edge when IssueValid=1.
REQ-022 SHALL clear busy[a] at the clock edge when either write port commits to address a.
REQ-023 SHALL, on same-cycle issue and write to the same address, leave busy set (issue wins).
REQ-024 SHALL drive RdyN = !busy[RSN], or 1 when BYPASS=1 and RSN is written this cycle and not simultaneously issued.
REQ-025 SHALL maintain BusyCount as a registered count equal to the population of busy bits after each edge; combined set/clear in one cycle SHALL net correctly (range 0..2**ADDR_W-1 with ZERO_REG=1).
REQ-026 SHALL accept issue to an already-busy register without changing BusyCount.

Reset
REQ-027 SHALL, on a clock edge with reset=0, clear all registers to 0, all busy bits to 0, BusyCount to 0 and WrConflict to 0.
REQ-028 SHALL give reset priority over any simultaneous write or issue; in-flight issues are discarded.
REQ-029 SHALL keep read outputs combinational during reset (reflecting array contents until the clearing edge).

Structure
REQ-030 SHALL place default DATA_W/ADDR_W constants and the register-0 address constant in the shared package regfile_pkg.
REQ-031 SHALL isolate the busy bits and BusyCount in one sub-module, regfile_scoreboard; the data array and forwarding stay in the top.

Verification
REQ-032 SHALL cover: write RD=3, 100 via port A; next cycle RS1=3 -> ReadData1=100.
REQ-033 SHALL cover: BYPASS=1, RS2=3 while writing 200 to RD=3 -> ReadData2=200 in the same cycle; with BYPASS=0 -> 100.
REQ-034 SHALL cover: RD=RD2=5, WriteData=7, WriteData2=9 -> reg5=7, WrConflict=1 for one cycle only.
REQ-035 SHALL cover: issue 4, then issue 6 -> BusyCount=2, Rdy1=0 for RS1=4; write 4 -> BusyCount=1, Rdy1=1.
REQ-036 SHALL cover: write 55 to RD=0 and issue 0 -> ReadData1=0, BusyCount unchanged.
REQ-037 SHALL cover: reset=0 mid-operation with 3 busy registers -> next cycle all reads 0, BusyCount=0, WrConflict=0.
